// File: rtl/tcam_ctrl_pkg.sv
// Shared op-codes and FSM state encoding for the TCAM controller.
package tcam_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_SEARCH = 2'b00,
        OP_WRITE  = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_WRITE,
        S_CLR_LO,
        S_CLR_HI,
        S_RESP
    } state_e;

endpackage

// File: rtl/tcam_ctrl_sat_cnt.sv
// Saturating up-counter used for the hit/miss statistics.
module tcam_ctrl_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/tcam_ctrl.sv
// Request/response front end for an external TCAM: search, single write,
// and a clear-all sweep that pulses the write strobe once per entry.
module tcam_ctrl
    import tcam_ctrl_pkg::*;
#(
    parameter int N         = 2,
    parameter int WORD_SIZE = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [WORD_SIZE-1:0] req_data,
    input  logic [WORD_SIZE-1:0] req_data_x,
    input  logic [N-1:0]         req_addr,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_hit,
    output logic [N-1:0]         resp_addr,
    output logic                 resp_err,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count,
    output logic [WORD_SIZE-1:0] t_data,
    output logic [WORD_SIZE-1:0] t_data_x,
    output logic                 t_w_r_bar,
    output logic [N-1:0]         t_write_address,
    input  logic [N-1:0]         t_address,
    input  logic                 t_match_flag
);

    localparam logic [N-1:0] LAST_IDX = '1;

    state_e       state, state_nxt;
    logic [N-1:0] idx;
    logic         search_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    case (op_e'(req_op))
                        OP_SEARCH: state_nxt = S_SEARCH;
                        OP_WRITE:  state_nxt = S_WRITE;
                        OP_CLEAR:  state_nxt = S_CLR_LO;
                        default:   state_nxt = S_RESP;
                    endcase
                end
            end
            S_SEARCH: state_nxt = S_RESP;
            S_WRITE:  state_nxt = S_RESP;
            S_CLR_LO: state_nxt = S_CLR_HI;
            S_CLR_HI: state_nxt = (idx == LAST_IDX) ? S_RESP : S_CLR_LO;
            S_RESP:   if (resp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign req_ready   = (state == S_IDLE);
    assign resp_valid  = (state == S_RESP);
    // The TCAM latches on a 0->1 strobe, hence the LO/HI pair per clear entry.
    assign t_w_r_bar   = (state == S_WRITE) || (state == S_CLR_HI);
    assign search_done = (state == S_SEARCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_data          <= '0;
            t_data_x        <= '0;
            t_write_address <= '0;
            idx             <= '0;
            resp_hit        <= 1'b0;
            resp_addr       <= '0;
            resp_err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        case (op_e'(req_op))
                            OP_SEARCH: begin
                                t_data   <= req_data;
                                t_data_x <= req_data_x;
                            end
                            OP_WRITE: begin
                                t_data          <= req_data;
                                t_data_x        <= req_data_x;
                                t_write_address <= req_addr;
                            end
                            OP_CLEAR: begin
                                t_data          <= '0;
                                t_data_x        <= '0;
                                t_write_address <= '0;
                                idx             <= '0;
                            end
                            default: begin
                                resp_hit  <= 1'b0;
                                resp_addr <= '0;
                                resp_err  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_SEARCH: begin
                    resp_hit  <= t_match_flag;
                    resp_addr <= t_address;
                    resp_err  <= 1'b0;
                end
                S_WRITE: begin
                    resp_hit  <= 1'b0;
                    resp_addr <= t_write_address;
                    resp_err  <= 1'b0;
                end
                S_CLR_HI: begin
                    if (idx == LAST_IDX) begin
                        resp_hit  <= 1'b0;
                        resp_addr <= '0;
                        resp_err  <= 1'b0;
                    end else begin
                        idx             <= idx + 1'b1;
                        t_write_address <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    tcam_ctrl_sat_cnt #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (search_done && t_match_flag),
        .count (hit_count)
    );

    tcam_ctrl_sat_cnt #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (search_done && !t_match_flag),
        .count (miss_count)
    );

endmodule

// File: tb/tb_tcam_ctrl.sv
// Scoreboard bench: tcam_ctrl wired to a behavioural TCAM, responses checked
// against an op-level reference model of contents and statistics.
module tb_tcam_ctrl;

    localparam int N     = 2;
    localparam int WS    = 2;
    localparam int CW    = 3;
    localparam int DEPTH = 4;
    localparam int CMAX  = 7;

    logic          clk, rst_n;
    logic          req_valid, req_ready;
    logic [1:0]    req_op;
    logic [WS-1:0] req_data, req_data_x;
    logic [N-1:0]  req_addr;
    logic          resp_valid, resp_ready, resp_hit, resp_err;
    logic [N-1:0]  resp_addr;
    logic [CW-1:0] hit_count, miss_count;
    logic [WS-1:0] t_data, t_data_x;
    logic          t_w_r_bar;
    logic [N-1:0]  t_write_address, t_address;
    logic          t_match_flag;

    tcam_ctrl #(.N(N), .WORD_SIZE(WS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_data_x(req_data_x), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_addr(resp_addr), .resp_err(resp_err),
        .hit_count(hit_count), .miss_count(miss_count),
        .t_data(t_data), .t_data_x(t_data_x), .t_w_r_bar(t_w_r_bar),
        .t_write_address(t_write_address),
        .t_address(t_address), .t_match_flag(t_match_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural TCAM: writes on a rising strobe, highest matching index wins.
    bit            tv[DEPTH];
    logic [WS-1:0] td[DEPTH], tm[DEPTH];
    bit            wr_prev = 1'b0;

    always @(posedge clk) begin
        if (t_w_r_bar && !wr_prev) begin
            tv[t_write_address] <= 1'b1;
            td[t_write_address] <= t_data;
            tm[t_write_address] <= t_data_x;
        end
        wr_prev <= t_w_r_bar;
    end

    always_comb begin
        t_match_flag = 1'b0;
        t_address    = '0;
        for (int i = 0; i < DEPTH; i++)
            if (tv[i] && (((t_data ^ td[i]) & ~tm[i] & ~t_data_x) == 2'b00)) begin
                t_match_flag = 1'b1;
                t_address    = i[N-1:0];
            end
    end

    // Reference model, updated once per accepted request.
    bit       rv[DEPTH];
    bit [1:0] rd[DEPTH], rm[DEPTH];
    int       rhit = 0, rmiss = 0;

    typedef struct {
        bit [1:0] op;
        bit       hit;
        bit [1:0] addr;
        bit       err;
        int       hitc;
        int       missc;
        int       lat;
        int       acc;
    } exp_t;
    exp_t q[$];

    function automatic void ref_search(input bit [1:0] k, input bit [1:0] km,
                                       output bit h, output bit [1:0] a);
        h = 1'b0;
        a = 2'b00;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (rv[i] && (((k ^ rd[i]) & ~rm[i] & ~km) == 2'b00)) begin
                h = 1'b1;
                a = i[1:0];
                return;
            end
    endfunction

    task automatic issue(input bit [1:0] op, input bit [1:0] d, input bit [1:0] m,
                         input bit [1:0] a, input bit track);
        int       n;
        exp_t     e;
        bit       h;
        bit [1:0] ha;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            chk("req_ready_timeout", 0, 1);
            return;
        end
        req_valid  = 1'b1;
        req_op     = op;
        req_data   = d;
        req_data_x = m;
        req_addr   = a;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!track) return;
        e.op = op; e.acc = cyc; e.hit = 1'b0; e.addr = 2'b00; e.err = 1'b0;
        // lat = rising edges between the accept edge and resp_valid showing up
        case (op)
            2'b00: begin
                ref_search(d, m, h, ha);
                e.hit = h; e.addr = ha;
                if (h) rhit = (rhit < CMAX) ? rhit + 1 : CMAX;
                else   rmiss = (rmiss < CMAX) ? rmiss + 1 : CMAX;
                e.lat = 1;
            end
            2'b01: begin
                rv[a] = 1'b1; rd[a] = d; rm[a] = m;
                e.addr = a;
                e.lat = 1;
            end
            2'b10: begin
                for (int i = 0; i < DEPTH; i++) begin
                    rv[i] = 1'b1; rd[i] = 2'b00; rm[i] = 2'b00;
                end
                e.lat = 2 * DEPTH;
            end
            default: begin
                e.err = 1'b1;
                e.lat = 0;
            end
        endcase
        e.hitc  = rhit;
        e.missc = rmiss;
        q.push_back(e);
    endtask

    // Monitor: pops on every response, then applies backpressure.
    initial begin
        exp_t     e;
        bit       first;
        int       hold;
        logic [3:0] snap;
        first = 1'b1;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && resp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - e.acc, e.lat);
                    chk("resp_err", resp_err, e.err);
                    if (e.op != 2'b11) begin
                        chk("resp_hit", resp_hit, e.hit);
                        chk("resp_addr", resp_addr, e.addr);
                    end
                    chk("hit_count", hit_count, e.hitc);
                    chk("miss_count", miss_count, e.missc);
                    chk("req_ready_busy", req_ready, 0);
                end
                hold = first ? 5 : int'($urandom_range(0, 3));
                first = 1'b0;
                snap = {resp_hit, resp_addr, resp_err};
                for (int k = 0; k < hold; k++) begin
                    @(negedge clk);
                    chk("hold_valid", resp_valid, 1);
                    chk("hold_payload", {resp_hit, resp_addr, resp_err}, snap);
                    chk("hold_req_ready", req_ready, 0);
                end
                resp_ready = 1'b1;
                @(negedge clk);
                resp_ready = 1'b0;
                chk("resp_drop", resp_valid, 0);
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_payload"}, {resp_hit, resp_addr, resp_err}, 0);
        chk({tag, "_counters"}, {hit_count, miss_count}, 0);
        chk({tag, "_t_w_r_bar"}, t_w_r_bar, 0);
        chk({tag, "_t_bus"}, {t_data, t_data_x, t_write_address}, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || resp_valid === 1'b1 || req_ready !== 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    initial begin
        int r;
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 2'b00; req_data = '0; req_data_x = '0; req_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("after_release");

        // Directed: write/search, don't-care entry, priority, reserved, clear.
        issue(2'b01, 2'b10, 2'b00, 2'd2, 1);
        issue(2'b00, 2'b10, 2'b00, 2'd0, 1);
        issue(2'b01, 2'b01, 2'b01, 2'd1, 1);
        issue(2'b00, 2'b00, 2'b00, 2'd0, 1);
        issue(2'b00, 2'b10, 2'b00, 2'd0, 1);
        issue(2'b11, 2'b11, 2'b11, 2'd3, 1);
        issue(2'b00, 2'b10, 2'b00, 2'd0, 1);
        issue(2'b10, 2'b00, 2'b00, 2'd0, 1);
        issue(2'b00, 2'b11, 2'b00, 2'd0, 1);

        // Drive both counters into saturation.
        repeat (CMAX + 2) issue(2'b00, 2'b11, 2'b00, 2'd0, 1);
        repeat (CMAX + 2) issue(2'b00, 2'b00, 2'b00, 2'd0, 1);

        repeat (80) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)
                issue(2'b00, 2'($urandom), (r == 0) ? 2'($urandom) : 2'b00, 2'($urandom), 1);
            else if (r < 8)
                issue(2'b01, 2'($urandom), 2'($urandom), 2'($urandom), 1);
            else if (r == 8)
                issue(2'b10, 2'($urandom), 2'($urandom), 2'($urandom), 1);
            else
                issue(2'b11, 2'($urandom), 2'($urandom), 2'($urandom), 1);
        end
        drain();

        // Reset in the middle of a clear sweep: no response may follow.
        issue(2'b10, 2'b00, 2'b00, 2'd0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_clear_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rhit = 0;
        rmiss = 0;
        repeat (10) @(negedge clk);
        chk("no_resp_after_reset", resp_valid, 0);

        issue(2'b10, 2'b00, 2'b00, 2'd0, 1);
        issue(2'b00, 2'b00, 2'b00, 2'd0, 1);
        issue(2'b00, 2'b01, 2'b00, 2'd0, 1);
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
